// File: rtl/alu_ram_pkg.sv
// Shared types and defaults for the ALU-RAM datapath.
// Holds the sequencer state encoding and width helpers.
package alu_ram_pkg;

  localparam int DATA_W_DEF      = 32;
  localparam int ADDR_W_DEF      = 4;
  localparam int LAST_ADDR_DEF   = 15;
  localparam int ALU_TIMEOUT_DEF = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WRITE,
    S_DONE
  } state_e;

  // Bits needed to hold values 0..limit.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/wait_counter.sv
// EXEC-state wait counter for the operand sequencer.
// expired_o flags the last allowed cycle of an ALU wait.
module wait_counter
  import alu_ram_pkg::*;
#(
  parameter int LIMIT = ALU_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = cnt_width(LIMIT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired_o = en_i && (cnt_q == CW'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rom_operand_sequencer.sv
// Walks operand ROM addresses, feeds the ALU and writes results to RAM.
// Every output is a register updated from the next-state decode.
module rom_operand_sequencer
  import alu_ram_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int LAST_ADDR   = LAST_ADDR_DEF,
  parameter int ALU_TIMEOUT = ALU_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              en_ROM,
  output logic [ADDR_W-1:0] addr_ROM,
  input  logic [DATA_W-1:0] op1_d,
  input  logic [DATA_W-1:0] op2_d,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_valid,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_result,
  output logic              we_RAM,
  output logic [ADDR_W-1:0] addr_RAM,
  output logic [DATA_W-1:0] data_RAM,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] arom_q, arom_d;
  logic [ADDR_W-1:0] aram_q, aram_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              en_q, en_d;
  logic              vld_q, vld_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic in_exec;
  logic expired;
  logic last;

  assign in_exec = (state_q == S_EXEC);
  assign last    = (idx_q == ADDR_W'(LAST_ADDR));

  wait_counter #(
    .LIMIT(ALU_TIMEOUT)
  ) u_wait (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (!in_exec),
    .en_i     (in_exec),
    .expired_o(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      arom_q  <= '0;
      aram_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      en_q    <= 1'b0;
      vld_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      arom_q  <= arom_d;
      aram_q  <= aram_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      en_q    <= en_d;
      vld_q   <= vld_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // A missing alu_done on the last allowed cycle aborts the run.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        if (alu_done) begin
          state_d = S_WRITE;
        end else if (expired) begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: state_d = last ? S_DONE : S_FETCH;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    idx_d  = idx_q;
    arom_d = arom_q;
    aram_d = aram_q;
    a_d    = a_q;
    b_d    = b_q;
    res_d  = res_q;
    err_d  = err_q;

    if (state_q == S_IDLE && start) begin
      idx_d = '0;
      err_d = 1'b0;
    end
    // ROM data is only trusted while en_ROM is high.
    if (state_q == S_FETCH) begin
      a_d = op1_d;
      b_d = op2_d;
    end
    if (in_exec) begin
      if (alu_done) begin
        res_d = alu_result;
      end else if (expired) begin
        err_d = 1'b1;
      end
    end
    if (state_q == S_WRITE && !last) begin
      idx_d = idx_q + ADDR_W'(1);
    end

    if (state_d == S_FETCH) arom_d = idx_d;
    if (state_d == S_WRITE) aram_d = idx_q;

    en_d   = (state_d == S_FETCH);
    vld_d  = (state_d == S_EXEC);
    we_d   = (state_d == S_WRITE);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign en_ROM    = en_q;
  assign addr_ROM  = arom_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_valid = vld_q;
  assign we_RAM    = we_q;
  assign addr_RAM  = aram_q;
  assign data_RAM  = res_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = err_q;

endmodule
